fifo_push_compact: RTL and testbench

FIFO_PUSH_COMPACT -- requirements
Module: fifo_push_compact

---
 rtl/fifo_push_compact.sv | 129 ++++++++++++
 tb/tb_fifo_push_compact.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fifo_push_compact.sv
// Packs sparse 4-lane input groups into a 4-slot buffer and drains it as a
// contiguous multi-push into a downstream FIFO, limited by its clear full prefix.
module fifo_push_compact #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_vld,
  input  logic [4*W-1:0] in_data,
  output logic           in_rdy,
  output logic           push_0,
  output logic           push_1,
  output logic           push_2,
  output logic           push_3,
  output logic [W-1:0]   push_0_data,
  output logic [W-1:0]   push_1_data,
  output logic [W-1:0]   push_2_data,
  output logic [W-1:0]   push_3_data,
  input  logic [3:0]     full,
  output logic [2:0]     pend_cnt
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // N sizes the downstream FIFO only; reject a degenerate value at elaboration.
  if (N == 0) begin : g_n_check
    $error("fifo_push_compact: N must be nonzero");
  end

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       slot_q [LANES];
  logic [W-1:0]       slot_d [LANES];
  logic [LANES-1:0][W-1:0] in_lanes;

  logic [CW-1:0]      avail_c;
  logic [CW-1:0]      drain_c;
  logic               accept_c;
  logic [CW-1:0]      pos;
  logic [CW-1:0]      src;

  assign in_lanes = in_data;

  // Length of the clear run of full starting at slot 0.
  always_comb begin
    casez (full)
      4'b???1: avail_c = 3'd0;
      4'b??10: avail_c = 3'd1;
      4'b?100: avail_c = 3'd2;
      4'b1000: avail_c = 3'd3;
      default: avail_c = 3'd4;
    endcase
  end

  assign drain_c  = (cnt_q < avail_c) ? cnt_q : avail_c;
  assign in_rdy   = !rst && (drain_c == cnt_q);
  assign accept_c = in_rdy && (in_vld != 4'b0000);

  assign push_0 = !rst && (drain_c > 3'd0);
  assign push_1 = !rst && (drain_c > 3'd1);
  assign push_2 = !rst && (drain_c > 3'd2);
  assign push_3 = !rst && (drain_c > 3'd3);

  assign push_0_data = slot_q[0];
  assign push_1_data = slot_q[1];
  assign push_2_data = slot_q[2];
  assign push_3_data = slot_q[3];
  assign pend_cnt    = cnt_q;

  // Next state: refill on accept, empty on idle ready, else shift down by drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos     = '0;
    src     = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      slot_d[j] = slot_q[j];
    end

    if (accept_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (in_vld[2'(i)]) begin
          slot_d[pos[1:0]] = in_lanes[2'(i)];
          pos = pos + 3'd1;
        end
      end
      cnt_d = pos;
    end else if (in_rdy) begin
      cnt_d = '0;
    end else begin
      for (int j = 0; j < int'(LANES); j++) begin
        src = 3'(j) + drain_c;
        if (!src[2]) begin
          slot_d[j] = slot_q[src[1:0]];
        end
      end
      cnt_d = cnt_q - drain_c;
    end

    case (state_q)
      ST_EMPTY: if (accept_c) state_d = ST_HOLD;
      ST_HOLD:  if ((drain_c == cnt_q) && !accept_c) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slot payload is never reset; only cnt_q marks which slots are meaningful.
  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(LANES); j++) begin
      slot_q[j] <= slot_d[j];
    end
  end

endmodule

// File: tb/tb_fifo_push_compact.sv
// Directed and random checks of fifo_push_compact against a queue-based model.
module tb_fifo_push_compact;

  localparam int unsigned W = 32;
  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_vld;
  logic [4*W-1:0] in_data;
  logic           in_rdy;
  logic           push_0, push_1, push_2, push_3;
  logic [W-1:0]   push_0_data, push_1_data, push_2_data, push_3_data;
  logic [3:0]     full;
  logic [2:0]     pend_cnt;

  always #5 clk = ~clk;

  fifo_push_compact #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .push_0(push_0), .push_1(push_1), .push_2(push_2), .push_3(push_3),
    .push_0_data(push_0_data), .push_1_data(push_1_data),
    .push_2_data(push_2_data), .push_3_data(push_3_data),
    .full(full), .pend_cnt(pend_cnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [W-1:0] mq [$];
  logic [W-1:0] pd [4];
  logic [3:0]   pushv;

  always_comb begin
    pd[0] = push_0_data;
    pd[1] = push_1_data;
    pd[2] = push_2_data;
    pd[3] = push_3_data;
    pushv = {push_3, push_2, push_1, push_0};
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] rnd_group();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive, check combinational outputs against the model, then advance it.
  task automatic step(input logic [3:0] vld, input logic [4*W-1:0] data,
                      input logic [3:0] f, input logic r);
    int av;
    int d;
    logic [3:0] exp_push;
    logic exp_rdy;
    @(negedge clk);
    in_vld = vld; in_data = data; full = f; rst = r;
    av = 0;
    while (av < 4 && !f[av]) av++;
    d = (mq.size() < av) ? mq.size() : av;
    exp_rdy = !r && (d == mq.size());
    exp_push = 4'b0000;
    if (!r) for (int i = 0; i < d; i++) exp_push[i] = 1'b1;
    #1;
    chk("pend_cnt", W'(pend_cnt), W'(mq.size()));
    chk("in_rdy", W'(in_rdy), W'(exp_rdy));
    chk("push_vec", W'(pushv), W'(exp_push));
    if (!r) for (int i = 0; i < d; i++) chk($sformatf("push_%0d_data", i), pd[i], mq[i]);
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      repeat (d) void'(mq.pop_front());
      if (exp_rdy) begin
        mq.delete();
        for (int i = 0; i < 4; i++) if (vld[i]) mq.push_back(data[i*W +: W]);
      end
    end
  endtask

  logic [4*W-1:0] g;
  logic [W-1:0]   a_word, b_word;
  logic [3:0]     rf;

  initial begin
    rst = 1'b1; in_vld = '0; in_data = '0; full = '0;
    step(4'h0, '0, 4'h0, 1'b1);
    step(4'hF, rnd_group(), 4'h0, 1'b1);
    // First cycle out of reset: empty, ready, no pushes.
    step(4'h0, '0, 4'h0, 1'b0);

    // Sparse compaction.
    a_word = 32'hAAAA_0001; b_word = 32'hBBBB_0003;
    g = rnd_group(); g[1*W +: W] = a_word; g[3*W +: W] = b_word;
    step(4'b1010, g, 4'h0, 1'b0);
    @(negedge clk); #1;
    chk("sparse_p0", push_0_data, a_word);
    chk("sparse_p1", push_1_data, b_word);
    chk("sparse_cnt", W'(pend_cnt), W'(2));
    step(4'h0, '0, 4'h0, 1'b0);
    step(4'h0, '0, 4'h0, 1'b0);

    // Partial drain, then refill in the same cycle as the final drain.
    step(4'hF, rnd_group(), 4'h0, 1'b0);
    step(4'h0, '0, 4'b0100, 1'b0);
    step(4'b0110, rnd_group(), 4'h0, 1'b0);
    step(4'h0, '0, 4'h0, 1'b0);

    // Stall with full[0] set, then release.
    step(4'b1101, rnd_group(), 4'h0, 1'b0);
    repeat (10) step(4'h0, '0, 4'b0001, 1'b0);
    step(4'h0, '0, 4'h0, 1'b0);

    // Back-to-back full groups.
    repeat (8) step(4'hF, rnd_group(), 4'h0, 1'b0);
    step(4'h0, '0, 4'h0, 1'b0);

    // Reset while entries are buffered and partially blocked.
    step(4'b0111, rnd_group(), 4'h0, 1'b0);
    step(4'h0, '0, 4'b0010, 1'b1);
    step(4'h0, '0, 4'h0, 1'b0);

    // Idle.
    repeat (5) step(4'h0, rnd_group(), 4'h0, 1'b0);

    // Random traffic with random full patterns and rare resets.
    repeat (400) begin
      rf = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(4'($urandom), rnd_group(), rf, $urandom_range(0, 49) == 0);
    end
    repeat (3) step(4'h0, '0, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
